fir_mac_sched: RTL and testbench

- Per-sample sequencer for the 64-tap FP16 FIR MAC datapath.
- On each input-sample strobe it writes the sample into the data ring buffer, then steps the shared multiply-accumulate unit through all taps, drains the MAC pipeline and flags the result valid.
- It also arbitrates the single coefficient-memory port between host coefficient loads and tap reads.
- Runs entirely in the fast clock domain. At 256 fast cycles per sample period, a full pass fits with margin.

---
 rtl/fir_mac_sched_if.sv | 33 +++
 rtl/fir_mac_sched.sv | 99 +++++++++
 tb/tb_fir_mac_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sched_if.sv
// Sequencer-side bus of the FIR MAC scheduler: sample strobe, host coefficient
// loads, memory address/enable outputs and MAC control.
interface fir_mac_sched_if #(
   parameter int unsigned AW = 6
);
   logic          sample_stb;
   logic          cload_req;
   logic [AW-1:0] cload_addr;
   logic          cload_grant;
   logic [AW-1:0] cmem_addr;
   logic          cmem_we;
   logic [AW-1:0] dmem_waddr;
   logic          dmem_we;
   logic [AW-1:0] dmem_raddr;
   logic          mac_en;
   logic          acc_clr;
   logic          out_valid;
   logic          busy;
   logic          overrun;
   logic          ovr_clr;

   modport master (
      output sample_stb, cload_req, cload_addr, ovr_clr,
      input  cload_grant, cmem_addr, cmem_we, dmem_waddr, dmem_we, dmem_raddr,
             mac_en, acc_clr, out_valid, busy, overrun
   );

   modport slave (
      input  sample_stb, cload_req, cload_addr, ovr_clr,
      output cload_grant, cmem_addr, cmem_we, dmem_waddr, dmem_we, dmem_raddr,
             mac_en, acc_clr, out_valid, busy, overrun
   );
endinterface

// File: rtl/fir_mac_sched.sv
// Per-sample sequencer for the FIR MAC datapath: writes the sample into the data ring,
// steps the MAC through all taps, drains the pipeline and arbitrates the coefficient port.
module fir_mac_sched #(
   parameter int unsigned NTAPS = 64,
   parameter int unsigned AW    = 6,
   parameter int unsigned PIPE  = 3
) (
   input  logic            clk,
   input  logic            rst,
   fir_mac_sched_if.slave  bus
);
   localparam int unsigned DW = (PIPE > 1) ? $clog2(PIPE) : 1;

   typedef enum logic [2:0] {IDLE, WRITE, RUN, DRAIN, DONE} state_t;

   state_t        state;
   state_t        state_nx;
   logic [AW-1:0] wptr;
   logic [AW-1:0] base;
   logic [AW-1:0] k;
   logic [DW-1:0] dcnt;
   logic          ovr;

   // State register plus the pointers and counters it steps
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wptr  <= '0;
         base  <= '0;
         k     <= '0;
         dcnt  <= '0;
         ovr   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            WRITE: begin
               base <= wptr;
               wptr <= wptr + AW'(1);
               k    <= '0;
            end
            RUN: begin
               // k saturates on the last tap so addresses hold through DRAIN
               if (k != AW'(NTAPS - 1)) k <= k + AW'(1);
               dcnt <= '0;
            end
            DRAIN:   dcnt <= dcnt + DW'(1);
            default: ;
         endcase
         if (bus.sample_stb && (state != IDLE)) ovr <= 1'b1;
         else if (bus.ovr_clr)                  ovr <= 1'b0;
      end
   end

   assign bus.overrun = ovr;

   // Next state and output decode
   always_comb begin
      state_nx        = state;
      bus.cload_grant = 1'b0;
      bus.cmem_we     = 1'b0;
      bus.cmem_addr   = k;
      bus.dmem_waddr  = wptr;
      bus.dmem_we     = 1'b0;
      bus.dmem_raddr  = base - k;
      bus.mac_en      = 1'b0;
      bus.acc_clr     = 1'b0;
      bus.out_valid   = 1'b0;
      bus.busy        = (state != IDLE);
      case (state)
         IDLE: begin
            // a sample strobe wins over a host load in the same cycle
            if (bus.sample_stb) begin
               state_nx = WRITE;
            end else if (bus.cload_req && !rst) begin
               bus.cload_grant = 1'b1;
               bus.cmem_we     = 1'b1;
               bus.cmem_addr   = bus.cload_addr;
            end
         end
         WRITE: begin
            bus.dmem_we = 1'b1;
            state_nx    = RUN;
         end
         RUN: begin
            bus.mac_en  = 1'b1;
            bus.acc_clr = (k == '0);
            if (k == AW'(NTAPS - 1)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (dcnt == DW'(PIPE - 1)) state_nx = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: a queue of expected passes is checked
// cycle by cycle by a monitor, plus directed checks for loads, overrun and reset.
module tb_fir_mac_sched;
   localparam int unsigned AW = 6;

   typedef struct {
      int         n;
      logic [5:0] base;
   } pass_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;
   logic [5:0] exp_wptr;
   pass_t sb[$];

   fir_mac_sched_if #(.AW(AW)) bus ();

   fir_mac_sched #(.NTAPS(64), .AW(AW), .PIPE(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle strobe; a pass is expected only when the DUT should be idle
   task automatic pulse_stb(output int n);
      n = cyc;
      bus.sample_stb = 1'b1;
      if (sb.size() == 0) begin
         sb.push_back('{n: cyc, base: exp_wptr});
         exp_wptr = exp_wptr + 6'd1;
      end
      tick();
      bus.sample_stb = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 300 && sb.size() != 0; i++) tick();
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL wait_idle timeout observed=busy expected=idle cyc=%0d", cyc);
         sb.delete();
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},    32'(bus.busy), 32'd0);
      chk({tag, "_mac_en"},  32'(bus.mac_en), 32'd0);
      chk({tag, "_acc_clr"}, 32'(bus.acc_clr), 32'd0);
      chk({tag, "_dmem_we"}, 32'(bus.dmem_we), 32'd0);
      chk({tag, "_out_vld"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_grant"},   32'(bus.cload_grant), 32'd0);
      chk({tag, "_cmem_we"}, 32'(bus.cmem_we), 32'd0);
      chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
      chk({tag, "_waddr"},   32'(bus.dmem_waddr), 32'd0);
      chk({tag, "_raddr"},   32'(bus.dmem_raddr), 32'd0);
      chk({tag, "_caddr"},   32'(bus.cmem_addr), 32'd0);
   endtask

   // Per-cycle check of the active pass (front of the scoreboard) and of load grants
   always @(negedge clk) begin : mon
      int         rel;
      bit         act;
      bit         gexp;
      logic [5:0] b;
      logic [5:0] kk;
      if (!rst) begin
         act = (sb.size() > 0) && ((cyc - sb[0].n) >= 1);
         rel = act ? (cyc - sb[0].n) : 0;
         b   = act ? sb[0].base : 6'd0;
         chk("busy", 32'(bus.busy), 32'(act));
         chk("dmem_we", 32'(bus.dmem_we), 32'(act && rel == 1));
         if (act && rel == 1) chk("dmem_waddr", 32'(bus.dmem_waddr), 32'(b));
         chk("mac_en", 32'(bus.mac_en), 32'(act && rel >= 2 && rel <= 65));
         chk("acc_clr", 32'(bus.acc_clr), 32'(act && rel == 2));
         if (act && rel >= 2 && rel <= 68) begin
            kk = (rel <= 65) ? 6'(rel - 2) : 6'd63;
            chk("cmem_addr", 32'(bus.cmem_addr), 32'(kk));
            chk("dmem_raddr", 32'(bus.dmem_raddr), 32'(6'(b - kk)));
         end
         chk("out_valid", 32'(bus.out_valid), 32'(act && rel == 69));
         gexp = !act && bus.cload_req && !bus.sample_stb;
         chk("cload_grant", 32'(bus.cload_grant), 32'(gexp));
         chk("cmem_we", 32'(bus.cmem_we), 32'(gexp));
         if (gexp) chk("cload_addr_fwd", 32'(bus.cmem_addr), 32'(bus.cload_addr));
         if (act && rel == 69) void'(sb.pop_front());
      end
   end

   initial begin
      int n;
      int grants;
      int first;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      exp_wptr = 6'd0;
      rst            = 1'b1;
      bus.sample_stb = 1'b0;
      bus.cload_req  = 1'b0;
      bus.cload_addr = '0;
      bus.ovr_clr    = 1'b0;

      // Power-on reset
      tick();
      tick();
      chk_reset_outputs("por");
      rst = 1'b0;
      repeat (3) tick();

      // Single sample then a second one: waddr 0 then 1, raddr sequences from the monitor
      pulse_stb(n);
      chk("s1_we", 32'(bus.dmem_we), 32'd1);
      chk("s1_waddr", 32'(bus.dmem_waddr), 32'd0);
      wait_idle();
      tick();
      chk("s1_busy_after", 32'(bus.busy), 32'd0);
      pulse_stb(n);
      chk("s2_waddr", 32'(bus.dmem_waddr), 32'd1);
      wait_idle();
      repeat (2) tick();

      // Coefficient load at 0x2A, same-cycle grant
      bus.cload_req  = 1'b1;
      bus.cload_addr = 6'h2A;
      #1;
      chk("cl_grant", 32'(bus.cload_grant), 32'd1);
      chk("cl_we", 32'(bus.cmem_we), 32'd1);
      chk("cl_addr", 32'(bus.cmem_addr), 32'h2A);
      tick();

      // Load all 64 addresses with the request held continuously
      grants = 0;
      for (int i = 0; i < 64; i++) begin
         bus.cload_addr = 6'(i);
         #1;
         if (bus.cload_grant) grants++;
         chk("cl_all_addr", 32'(bus.cmem_addr), 32'(i));
         tick();
      end
      bus.cload_req = 1'b0;
      chk("cl_all_grants", 32'(grants), 32'd64);
      tick();

      // Strobe and load in the same idle cycle; load held through the pass
      bus.cload_req  = 1'b1;
      bus.cload_addr = 6'h05;
      bus.sample_stb = 1'b1;
      #1;
      chk("ct_no_grant", 32'(bus.cload_grant), 32'd0);
      bus.sample_stb = 1'b0;
      #1;
      bus.sample_stb = 1'b1;
      pulse_stb(n);
      first = -1;
      for (int j = 0; j < 200; j++) begin
         if (bus.cload_grant) begin
            first = cyc;
            break;
         end
         tick();
      end
      chk("ct_first_grant", 32'(first), 32'(n + 70));
      bus.cload_req = 1'b0;
      tick();
      tick();

      // Overrun mid-pass, then set and clear together, then clear alone
      pulse_stb(n);
      while (cyc < n + 30) tick();
      pulse_stb(first);
      chk("ovr_set", 32'(bus.overrun), 32'd1);
      while (cyc < n + 40) tick();
      bus.ovr_clr = 1'b1;
      pulse_stb(first);
      bus.ovr_clr = 1'b0;
      chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
      wait_idle();
      tick();
      chk("ovr_held_idle", 32'(bus.overrun), 32'd1);
      bus.ovr_clr = 1'b1;
      tick();
      bus.ovr_clr = 1'b0;
      chk("ovr_cleared", 32'(bus.overrun), 32'd0);
      tick();

      // Back-to-back samples until the write pointer wraps
      pulse_stb(n);
      while (exp_wptr != 6'd0) begin
         for (int j = 0; j < 300 && sb.size() != 0; j++) tick();
         pulse_stb(n);
      end
      wait_idle();
      pulse_stb(n);
      chk("wrap_we", 32'(bus.dmem_we), 32'd1);
      chk("wrap_waddr", 32'(bus.dmem_waddr), 32'd0);
      wait_idle();
      tick();

      // Reset during RUN: no out_valid, wptr back to 0
      pulse_stb(n);
      while (cyc < n + 30) tick();
      pulse_stb(first);
      chk("rst_pre_ovr", 32'(bus.overrun), 32'd1);
      while (cyc < n + 40) tick();
      rst = 1'b1;
      sb.delete();
      exp_wptr = 6'd0;
      tick();
      chk_reset_outputs("mid");
      tick();
      rst = 1'b0;
      repeat (40) tick();
      pulse_stb(n);
      chk("post_rst_we", 32'(bus.dmem_we), 32'd1);
      chk("post_rst_waddr", 32'(bus.dmem_waddr), 32'd0);
      wait_idle();
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
